// File: rtl/pio_pkg.sv
// Shared constants for the debounced PIO input block.
// Register addresses, edge selection codes and the edge matcher.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_hit(
    input int   kind,
    input logic from_v,
    input logic to_v
  );
    case (kind)
      EDGE_RISE: return !from_v && to_v;
      EDGE_FALL: return from_v && !to_v;
      default:   return from_v != to_v;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, debounce counter, stable flop
// and a registered one-cycle edge pulse.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic load,
  input  logic din,
  output logic stable,
  output logic edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CW-1:0]          cnt;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= '0;
      stable     <= 1'b0;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], din};
      edge_pulse <= 1'b0;
      if (load) begin
        // first valid sample after reset: adopt it, no edge
        stable <= synced;
        cnt    <= '0;
      end else if (!hold) begin
        if (synced == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          stable     <= synced;
          cnt        <= '0;
          edge_pulse <= edge_hit(EDGE_TYPE, stable, synced);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pio_input_irq.sv
// Debounced parallel input port with edge capture, irq mask
// and a small register interface.
module pio_input_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [IW-1:0] INIT_LOAD = IW'(SYNC_STAGES);
  localparam logic [IW-1:0] INIT_DONE = IW'(SYNC_STAGES + 1);

  logic [IW-1:0]    init_cnt;
  logic             hold;
  logic             load;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr;
  logic             unused_wdata;

  assign hold = init_cnt < INIT_LOAD;
  assign load = init_cnt == INIT_LOAD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (init_cnt != INIT_DONE) begin
      init_cnt <= init_cnt + IW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .load      (load),
      .din       (in_port[i]),
      .stable    (data[i]),
      .edge_pulse(edges[i])
    );
  end

  assign clr = (write && address == ADDR_EDGECAP)
             ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      if (write && address == ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      // a fresh edge outranks a same-cycle clear
      edgecap <= (edgecap & ~clr) | edges;
      case (address)
        ADDR_DATA:    readdata <= 32'(data);
        ADDR_IRQMASK: readdata <= 32'(irqmask);
        ADDR_EDGECAP: readdata <= 32'(edgecap);
        default:      readdata <= '0;
      endcase
    end
  end

  assign irq          = |(edgecap & irqmask);
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_input_irq.sv
// Directed bench for pio_input_irq with hand-computed expectations.
// Inputs change on the falling edge; outputs sampled on the falling edge.
module tb_pio_input_irq;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pio_input_irq #(
    .WIDTH          (3),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .in_port  (in_port),
    .readdata (readdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    address = a;
    write   = 1'b0;
    @(negedge clk);
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    address   = 2'd0;
    write     = 1'b0;
    writedata = 32'd0;
    in_port   = 3'b101;

    // reset state and init reload of held inputs
    cyc(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    cyc(10);
    rd(2'd0, 32'h5, "s1_data");
    rd(2'd3, 32'h0, "s1_edgecap");
    check("s1_irq", {31'd0, irq}, 32'h0);

    // bit1 rising edge, exact debounce latency
    wr(2'd2, 32'h2);
    @(negedge clk);
    address = 2'd0;
    in_port = 3'b111;
    cyc(6);
    check("s2_data_p6", readdata, 32'h5);
    check("s2_irq_p6", {31'd0, irq}, 32'h0);
    cyc(1);
    check("s2_data_p7", readdata, 32'h7);
    check("s2_irq_p7", {31'd0, irq}, 32'h1);
    rd(2'd3, 32'h2, "s2_edgecap");
    wr(2'd3, 32'h2);
    check("s2_irq_clr", {31'd0, irq}, 32'h0);
    rd(2'd3, 32'h0, "s2_edgecap_clr");

    // 3-cycle low glitch on bit0 is filtered
    @(negedge clk);
    in_port = 3'b110;
    cyc(3);
    in_port = 3'b111;
    cyc(10);
    rd(2'd0, 32'h7, "s3_data");
    rd(2'd3, 32'h0, "s3_edgecap");
    check("s3_irq", {31'd0, irq}, 32'h0);

    // same-cycle clear and set on bit2: set wins
    @(negedge clk);
    in_port = 3'b011;
    cyc(10);
    in_port = 3'b111;
    cyc(10);
    rd(2'd3, 32'h4, "s4_first_edge");
    @(negedge clk);
    in_port = 3'b011;
    cyc(10);
    in_port = 3'b111;
    cyc(6);
    address   = 2'd3;
    writedata = 32'h4;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    rd(2'd3, 32'h4, "s4_set_wins");
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h0, "s4_plain_clr");

    // masked edge, then unmask; reserved and mask width
    wr(2'd2, 32'h0);
    @(negedge clk);
    in_port = 3'b110;
    cyc(10);
    in_port = 3'b111;
    cyc(10);
    rd(2'd3, 32'h1, "s5_edgecap");
    check("s5_irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h7);
    check("s5_irq_unmasked", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "s5_rsvd");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h7, "s5_mask_width");
    wr(2'd0, 32'h0);
    rd(2'd0, 32'h7, "s5_data_ro");
    @(negedge clk);
    address   = 2'd2;
    writedata = 32'h0;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("s5_read_old", readdata, 32'h7);
    rd(2'd2, 32'h0, "s5_read_new");
    wr(2'd2, 32'h7);

    // reset in the middle of a bit2 debounce
    @(negedge clk);
    in_port = 3'b011;
    cyc(10);
    rd(2'd0, 32'h3, "s6_pre_data");
    check("s6_pre_irq", {31'd0, irq}, 32'h1);
    in_port = 3'b111;
    cyc(4);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_readdata", readdata, 32'h0);
    check("s6_rst_irq", {31'd0, irq}, 32'h0);
    cyc(2);
    reset = 1'b0;
    cyc(3);
    check("s6_init_hold", readdata, 32'h0);
    cyc(1);
    check("s6_init_load", readdata, 32'h7);
    cyc(8);
    rd(2'd3, 32'h0, "s6_no_edge");
    rd(2'd2, 32'h0, "s6_mask_rst");
    check("s6_irq", {31'd0, irq}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_input_irq.md
PIO_INPUT_IRQ -- requirements
Module: pio_input_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 3; number of input bits, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; synchroniser flops per bit, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4; consecutive stable cycles required before accepting a change, legal range 1..65535.
REQ-004 SHALL have parameter EDGE_TYPE, default 0; 0=rising, 1=falling, 2=any edge.
REQ-005 clk  input  1  single clock; all state is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  2  register select.
REQ-008 write  input  1  write strobe, single-cycle.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 Each in_port bit SHALL pass through SYNC_STAGES flops, then a per-bit debouncer.
REQ-014 Debouncer: when the synced bit differs from the stable bit for DEBOUNCE_CYCLES consecutive cycles, the stable bit SHALL take the synced value; any cycle of agreement restarts the count at 0.
REQ-015 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-016 Init phase: for SYNC_STAGES cycles after reset deassertion, stable bits SHALL NOT update; on the following cycle each stable bit SHALL load the synced value directly, and no edge SHALL be captured.
REQ-017 Edge event per bit: a stable-bit transition matching EDGE_TYPE. This sets edgecapture[i] on the next clock.
REQ-018 Register map: 0=data (stable bits, RO); 1=reserved (reads 0, writes ignored); 2=irqmask (RW, WIDTH bits); 3=edgecapture (write-1-to-clear).
REQ-019 A write to edgecapture clears each bit where writedata is 1.
REQ-020 If a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-021 Writes to irqmask SHALL take effect on the next clock; writedata bits at or above WIDTH SHALL be ignored.
REQ-022 readdata SHALL update every cycle with the selected register, zero-extended to 32 bits; latency is 1 cycle from address.
REQ-023 readdata SHALL be independent of write in the same cycle; it reflects register state before that cycle's update.
REQ-024 irq SHALL equal |(edgecapture & irqmask), driven from registered state only, with no combinational path from address, write or in_port.
REQ-025 Input pulses shorter than DEBOUNCE_CYCLES after synchronisation SHALL produce no data change and no edge.

Reset
REQ-026 When reset is asserted, all of the following SHALL asynchronously clear to 0: synchroniser flops, stable bits, debounce counters, the init counter, irqmask, edgecapture, readdata and irq.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; after release, the init phase of REQ-016 SHALL restart.

Structure
REQ-028 Package pio_pkg SHALL hold the address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3 and the edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY.
REQ-029 Sub-module pio_debounce_bit SHALL contain one bit's synchroniser, debounce counter, stable flop and edge pulse output, with parameters SYNC_STAGES, DEBOUNCE_CYCLES and EDGE_TYPE.
REQ-030 The top level SHALL instantiate pio_debounce_bit WIDTH times through generate, and SHALL own the register file, read mux and irq.

Verification
REQ-031 Bench parameters SHALL be WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0.
REQ-032 Scenario 1: in_port=3'b101 held through reset release; read addr 0 after 10 cycles -> readdata=0x5, edgecapture=0, irq=0.
REQ-033 Scenario 2: in_port bit1 0->1 held, irqmask=3'b010 -> data bit1 set exactly 2+4 cycles after the change (plus 1 edge cycle), edgecapture=0x2, irq=1; write 0x2 to addr 3 -> edgecapture=0, irq=0.
REQ-034 Scenario 3: 3-cycle glitch on bit0 -> data unchanged, edgecapture=0, irq stays 0.
REQ-035 Scenario 4: W1C of bit2 in the same cycle as a new bit2 rising edge -> edgecapture bit2 remains 1.
REQ-036 Scenario 5: edge captured with irqmask=0 -> irq=0; write irqmask=0x7 -> irq=1 the next cycle; read addr 1 -> 0; write 0xFFFFFFFF to addr 2, read back -> 0x7.
REQ-037 Scenario 6: reset asserted 2 cycles into a debounce -> all outputs 0 immediately; after release, init reload occurs with no spurious edge.
